au_issue_unit: RTL and testbench

- Sequencer directly upstream of arithmetic_unit. Accepts 32-bit instruction words over a valid/ready handshake and decodes them.
- Owns an 8x32 register file and reads operands from it; fetches the memory operand through a 1-cycle-latency read port.
- Drives arithmetic_unit's ACT/OP_CODE/MOVI/operand inputs, waits for DATA_VALID, then writes the result back and reports it on a result port.
- Processes one instruction at a time. No pipelining, no forwarding.

---
 rtl/au_issue_unit.sv | 192 +++++++++++++++++++
 tb/tb_au_issue_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_issue_unit.sv
// au_issue_unit: single-issue sequencer in front of arithmetic_unit.
// Decodes one instruction at a time, gathers operands, issues, waits and writes back.
module au_issue_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MEM_ADDR_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           INSTR,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  output logic                  MEM_REN,
  output logic [MEM_ADDR_W-1:0] MEM_ADDR,
  input  logic [31:0]           MEM_RDATA,
  output logic                  AU_ACT,
  output logic [1:0]            AU_OP_CODE,
  output logic [1:0]            AU_MOVI,
  output logic [31:0]           AU_REG_A,
  output logic [31:0]           AU_REG_B,
  output logic [31:0]           AU_MEM,
  output logic [31:0]           AU_IMM,
  input  logic [31:0]           AU_DATA,
  input  logic                  AU_DATA_VALID,
  output logic                  RES_VALID,
  output logic [31:0]           RES_DATA,
  output logic [2:0]            RES_RD,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_RD,
    S_MEM_WAIT,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        movi_q, movi_d;
  logic [2:0]        rd_q, rd_d;
  logic [31:0]       reg_a_q, reg_a_d;
  logic [31:0]       reg_b_q, reg_b_d;
  logic [31:0]       mem_q, mem_d;
  logic [31:0]       imm_q, imm_d;
  logic [31:0]       res_data_q, res_data_d;
  logic [2:0]        res_rd_q, res_rd_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rf_q [8];
  logic [31:0]       rf_d [8];

  logic [2:0]        dec_ra;
  logic [2:0]        dec_rb;
  logic [31:0]       rd_a_val;
  logic [31:0]       rd_b_val;
  logic              unused_instr_bits;

  assign dec_ra            = INSTR[24:22];
  assign dec_rb            = INSTR[21:19];
  assign unused_instr_bits = ^INSTR[18:16];

  // R0 is hard-wired to zero regardless of what the array holds.
  always_comb begin
    rd_a_val = (dec_ra == 3'd0) ? 32'd0 : rf_q[dec_ra];
    rd_b_val = (dec_rb == 3'd0) ? 32'd0 : rf_q[dec_rb];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    movi_d     = movi_q;
    rd_d       = rd_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    mem_d      = mem_q;
    imm_d      = imm_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < 8; i++) begin
      rf_d[i] = rf_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (INSTR_VALID) begin
          op_d    = INSTR[31:30];
          movi_d  = INSTR[29:28];
          rd_d    = INSTR[27:25];
          reg_a_d = rd_a_val;
          reg_b_d = rd_b_val;
          imm_d   = {{16{INSTR[15]}}, INSTR[15:0]};
          state_d = (INSTR[29:28] == 2'b01) ? S_MEM_RD : S_ISSUE;
        end
      end
      S_MEM_RD: begin
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        mem_d   = MEM_RDATA;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A late result wins over a timeout landing in the same cycle.
        if (AU_DATA_VALID) begin
          res_data_d = AU_DATA;
          res_rd_d   = rd_q;
          state_d    = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        if (rd_q != 3'd0) begin
          rf_d[rd_q] = res_data_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      movi_q     <= '0;
      rd_q       <= '0;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      mem_q      <= '0;
      imm_q      <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      movi_q     <= movi_d;
      rd_q       <= rd_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      mem_q      <= mem_d;
      imm_q      <= imm_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Operands come straight from registers so the AU can resample them mid-MUL.
  assign INSTR_READY = (state_q == S_IDLE);
  assign BUSY        = (state_q != S_IDLE);
  assign MEM_REN     = (state_q == S_MEM_RD);
  assign MEM_ADDR    = (state_q == S_MEM_RD) ? imm_q[MEM_ADDR_W-1:0] : '0;
  assign AU_ACT      = (state_q == S_ISSUE);
  assign AU_OP_CODE  = op_q;
  assign AU_MOVI     = movi_q;
  assign AU_REG_A    = reg_a_q;
  assign AU_REG_B    = reg_b_q;
  assign AU_MEM      = mem_q;
  assign AU_IMM      = imm_q;
  assign RES_VALID   = (state_q == S_WB);
  assign RES_DATA    = res_data_q;
  assign RES_RD      = res_rd_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_au_issue_unit.sv
// Testbench for au_issue_unit: behavioural arithmetic_unit and memory around the DUT,
// table-driven instruction stream with a result scoreboard, plus timeout and reset sequences.
module tb_au_issue_unit;

  localparam int TIMEOUT = 16;
  localparam int AW      = 8;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] mem_val;
    logic [31:0] exp_data;
    logic [2:0]  exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  rd;
    int          lat;
    int          ren;
    logic [7:0]  addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          au_act;
  logic [1:0]    au_op_code;
  logic [1:0]    au_movi;
  logic [31:0]   au_reg_a;
  logic [31:0]   au_reg_b;
  logic [31:0]   au_mem;
  logic [31:0]   au_imm;
  logic [31:0]   au_data;
  logic          au_data_valid;
  logic          res_valid;
  logic [31:0]   res_data;
  logic [2:0]    res_rd;
  logic          busy;
  logic          err;

  int            checks   = 0;
  int            failures = 0;
  int            cycle    = 0;
  logic          au_enable;
  logic [31:0]   mem [256];
  exp_t          sb [$];

  au_issue_unit #(.TIMEOUT_CYCLES(TIMEOUT), .MEM_ADDR_W(AW)) dut (
    .CLK(clk), .RST(rst),
    .INSTR(instr), .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready),
    .MEM_REN(mem_ren), .MEM_ADDR(mem_addr), .MEM_RDATA(mem_rdata),
    .AU_ACT(au_act), .AU_OP_CODE(au_op_code), .AU_MOVI(au_movi),
    .AU_REG_A(au_reg_a), .AU_REG_B(au_reg_b), .AU_MEM(au_mem), .AU_IMM(au_imm),
    .AU_DATA(au_data), .AU_DATA_VALID(au_data_valid),
    .RES_VALID(res_valid), .RES_DATA(res_data), .RES_RD(res_rd),
    .BUSY(busy), .ERR(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [1:0] movi,
                                     input logic [2:0] rd, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic [15:0] imm);
    return {op, movi, rd, ra, rb, 3'b000, imm};
  endfunction

  function automatic logic [31:0] auCompute(input logic [1:0] op, input logic [1:0] movi,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] m, input logic [31:0] imm);
    logic [31:0] s;
    s = (movi == 2'b00) ? b : (movi == 2'b01) ? m : imm;
    case (op)
      2'b00:   return a + s;
      2'b01:   return a - s;
      2'b10:   return a * s;
      default: return (s == 32'd0) ? 32'd0 : a / s;
    endcase
  endfunction

  // Memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  // Arithmetic unit model: result one cycle after ACT, MUL three cycles later and
  // recomputed from the operand inputs at completion.
  logic au_pend;
  int   au_cnt;
  always @(posedge clk) begin
    if (rst) begin
      au_data_valid <= 1'b0;
      au_data       <= '0;
      au_pend       <= 1'b0;
      au_cnt        <= 0;
    end else begin
      au_data_valid <= 1'b0;
      if (au_pend) begin
        if (au_cnt == 0) begin
          au_pend       <= 1'b0;
          au_data_valid <= 1'b1;
          au_data       <= auCompute(au_op_code, au_movi, au_reg_a, au_reg_b, au_mem, au_imm);
        end else begin
          au_cnt <= au_cnt - 1;
        end
      end else if (au_act && au_enable) begin
        if (au_op_code == 2'b10) begin
          au_pend <= 1'b1;
          au_cnt  <= 2;
        end else begin
          au_data_valid <= 1'b1;
          au_data       <= auCompute(au_op_code, au_movi, au_reg_a, au_reg_b, au_mem, au_imm);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: per-transaction bookkeeping, result comparison against the scoreboard.
  int           hs_cycle = 0;
  int           act_cnt  = 0;
  int           ren_cnt  = 0;
  logic [7:0]   ren_addr = '0;
  bit           have_snap = 0;
  bit           stable    = 1;
  logic [131:0] snap;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      have_snap = 0;
    end else begin
      if (instr_valid && instr_ready) begin
        hs_cycle  = cycle;
        act_cnt   = 0;
        ren_cnt   = 0;
        ren_addr  = '0;
        have_snap = 0;
        stable    = 1;
      end
      if (au_act) begin
        act_cnt++;
        snap      = {au_op_code, au_movi, au_reg_a, au_reg_b, au_mem, au_imm};
        have_snap = 1;
      end else if (have_snap && busy &&
                   snap != {au_op_code, au_movi, au_reg_a, au_reg_b, au_mem, au_imm}) begin
        stable = 0;
      end
      if (mem_ren) begin
        ren_cnt++;
        ren_addr = mem_addr;
      end
      if (res_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_res: got RES_VALID data 0x%08h rd %0d, expected none",
                   res_data, res_rd);
        end else begin
          e = sb.pop_front();
          checkOutput("res_data", res_data, e.data);
          checkOutput("res_rd", 32'(res_rd), 32'(e.rd));
          checkOutput("res_latency", 32'(cycle - hs_cycle), 32'(e.lat));
          checkOutput("au_act_pulses", 32'(act_cnt), 32'd1);
          checkOutput("mem_ren_pulses", 32'(ren_cnt), 32'(e.ren));
          if (e.ren != 0) checkOutput("mem_addr", 32'(ren_addr), 32'(e.addr));
          checkOutput("operand_stable", 32'(stable), 32'd1);
          checkOutput("ready_in_wb", 32'(instr_ready), 32'd0);
        end
      end
    end
  end

  // Called at posedge+1; waits for READY, offers the word, returns one edge after acceptance.
  task automatic applyStimulus(input logic [31:0] w, input logic [31:0] mv,
                               input logic [31:0] ed, input logic [2:0] er, input int el,
                               input bit push, input bit hold);
    exp_t e;
    int   n = 0;
    while (!instr_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_wait: got INSTR_READY=0 after %0d cycles, expected 1", n);
      instr_valid = 1'b0;
      return;
    end
    if (w[29:28] == 2'b01) mem[w[7:0]] = mv;
    if (push) begin
      e.data = ed;
      e.rd   = er;
      e.lat  = el;
      e.ren  = (w[29:28] == 2'b01) ? 1 : 0;
      e.addr = w[7:0];
      sb.push_back(e);
    end
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    instr_valid = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, 32'(instr_ready), 32'd1);
    checkOutput({tag, "_busy_err"}, {30'd0, busy, err}, 32'd0);
    checkOutput({tag, "_ctrl"}, {22'd0, mem_ren, mem_addr, au_act, res_valid}, 32'd0);
    checkOutput({tag, "_fields"}, {25'd0, au_op_code, au_movi, res_rd}, 32'd0);
    checkOutput({tag, "_data"}, au_reg_a | au_reg_b | au_mem | au_imm | res_data, 32'd0);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{mk(2'b00, 2'b10, 3'd1, 3'd0, 3'd0, 16'h0005), 32'd0, 32'd5,         3'd1, 3};
    vecs[1] = '{mk(2'b01, 2'b10, 3'd2, 3'd1, 3'd0, 16'hFFFF), 32'd0, 32'd6,         3'd2, 3};
    vecs[2] = '{mk(2'b10, 2'b00, 3'd3, 3'd1, 3'd1, 16'h0000), 32'd0, 32'd25,        3'd3, 6};
    vecs[3] = '{mk(2'b11, 2'b01, 3'd4, 3'd3, 3'd0, 16'h0010), 32'd5, 32'd5,         3'd4, 5};
    vecs[4] = '{mk(2'b11, 2'b01, 3'd4, 3'd3, 3'd0, 16'h0010), 32'd0, 32'd0,         3'd4, 5};
    vecs[5] = '{mk(2'b00, 2'b00, 3'd0, 3'd1, 3'd1, 16'h0000), 32'd0, 32'd10,        3'd0, 3};
    vecs[6] = '{mk(2'b00, 2'b00, 3'd5, 3'd0, 3'd0, 16'h0000), 32'd0, 32'd0,         3'd5, 3};
    vecs[7] = '{mk(2'b10, 2'b01, 3'd6, 3'd2, 3'd0, 16'h0022), 32'd7, 32'd42,        3'd6, 8};
    vecs[8] = '{mk(2'b01, 2'b00, 3'd1, 3'd1, 3'd2, 16'h0000), 32'd0, 32'hFFFFFFFF,  3'd1, 3};
    vecs[9] = '{mk(2'b00, 2'b00, 3'd7, 3'd1, 3'd0, 16'h0000), 32'd0, 32'hFFFFFFFF,  3'd7, 3};

    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | i;
    rst         = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    au_enable   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back stream with INSTR_VALID held high while each instruction runs.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].mem_val, vecs[i].exp_data, vecs[i].exp_rd,
                    vecs[i].exp_lat, 1'b1, 1'b1);
    end
    drain();
    checkOutput("err_after_div0", 32'(err), 32'd0);

    // Timeout: AU never answers; ERR rises after exactly TIMEOUT wait cycles.
    au_enable = 1'b0;
    applyStimulus(mk(2'b00, 2'b10, 3'd1, 3'd1, 3'd0, 16'h0001), 32'd0, 32'd0, 3'd0, 0, 1'b0, 1'b0);
    repeat (TIMEOUT) @(posedge clk);
    #1;
    checkOutput("timeout_not_yet", {30'd0, busy, err}, 32'd2);
    @(posedge clk); #1;
    checkOutput("timeout_err", {29'd0, instr_ready, busy, err}, 32'd5);
    au_enable = 1'b1;

    // ERR is sticky across a later successful instruction; R1 was not written.
    applyStimulus(mk(2'b00, 2'b10, 3'd6, 3'd7, 3'd0, 16'h0001), 32'd0, 32'd0, 3'd6, 3, 1'b1, 1'b0);
    drain();
    checkOutput("err_sticky", 32'(err), 32'd1);

    // Reset while a MUL is waiting on the AU.
    applyStimulus(mk(2'b10, 2'b00, 3'd3, 3'd1, 3'd1, 16'h0000), 32'd0, 32'd0, 3'd0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_mul_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetState("midop_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(mk(2'b00, 2'b00, 3'd5, 3'd3, 3'd0, 16'h0000), 32'd0, 32'd0, 3'd5, 3, 1'b1, 1'b0);
    drain();
    checkOutput("err_after_reset", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
